// File: rtl/rf_wb_arbiter_if.sv
// Write-back port bundle: two requesters, decode issue/source lookup,
// and the register-file write port with the scoreboard.
// Handshake: a write moves on a posedge where x_valid && x_ready; the
// requester holds x_rd/x_data stable until that edge, and x_ready is
// a combinational function of both valids and the last grant.
interface rf_wb_arbiter_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   localparam int NREG = 1 << ADDR_W;

   logic                  a_valid;
   logic [ADDR_W-1:0]     a_rd;
   logic [DATA_W-1:0]     a_data;
   logic                  a_ready;
   logic                  b_valid;
   logic [ADDR_W-1:0]     b_rd;
   logic [DATA_W-1:0]     b_data;
   logic                  b_ready;
   logic                  issue_valid;
   logic [ADDR_W-1:0]     issue_rd;
   logic [2*ADDR_W-1:0]   rs_rt;
   logic                  hazard;
   logic [ADDR_W-1:0]     rwd;
   logic [DATA_W-1:0]     wb_data;
   logic [NREG-1:0]       pending;
   logic                  last_grant;  // debug view of the arbiter state (1 = B)

   modport master (
      output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
             issue_valid, issue_rd, rs_rt,
      input  a_ready, b_ready, hazard, rwd, wb_data, pending, last_grant
   );

   modport slave (
      input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
             issue_valid, issue_rd, rs_rt,
      output a_ready, b_ready, hazard, rwd, wb_data, pending, last_grant
   );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Round-robin write-back arbiter for the register file's single write
// port, with a pending-write scoreboard that drives the decode hazard.
module rf_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic          CLK,
   input  logic          RST,
   rf_wb_arbiter_if.slave bus
);
   localparam int NREG = 1 << ADDR_W;

   typedef enum logic {
      GRANT_A = 1'b0,
      GRANT_B = 1'b1
   } grant_t;

   grant_t              last_q;
   logic [ADDR_W-1:0]   rwd_q;
   logic [DATA_W-1:0]   wb_data_q;
   logic [NREG-1:0]     pending_q;

   logic                a_ready_c;
   logic                b_ready_c;
   logic                a_xfer;
   logic                b_xfer;
   logic [NREG-1:0]     set_mask;
   logic [NREG-1:0]     clr_mask;
   logic [ADDR_W-1:0]   rs;
   logic [ADDR_W-1:0]   rt;
   logic                hazard_c;

   // Grant: a lone requester wins; under contention the side not granted last time wins.
   always_comb begin
      a_ready_c = 1'b0;
      b_ready_c = 1'b0;
      if (!RST) begin
         a_ready_c = bus.a_valid && (!bus.b_valid || last_q == GRANT_B);
         b_ready_c = bus.b_valid && (!bus.a_valid || last_q == GRANT_A);
      end
   end

   assign a_xfer = bus.a_valid && a_ready_c;
   assign b_xfer = bus.b_valid && b_ready_c;

   // Output register and arbiter state; rd = 0 passes through as "no write".
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         last_q    <= GRANT_B;
         rwd_q     <= '0;
         wb_data_q <= '0;
      end else if (a_xfer) begin
         last_q    <= GRANT_A;
         rwd_q     <= bus.a_rd;
         wb_data_q <= bus.a_data;
      end else if (b_xfer) begin
         last_q    <= GRANT_B;
         rwd_q     <= bus.b_rd;
         wb_data_q <= bus.b_data;
      end else begin
         rwd_q     <= '0;
      end
   end

   // Scoreboard masks: issue sets, a committed write clears; register 0 is never tracked.
   always_comb begin
      set_mask = '0;
      clr_mask = '0;
      if (bus.issue_valid && bus.issue_rd != '0)
         set_mask[bus.issue_rd] = 1'b1;
      if (a_xfer && bus.a_rd != '0)
         clr_mask[bus.a_rd] = 1'b1;
      else if (b_xfer && bus.b_rd != '0)
         clr_mask[bus.b_rd] = 1'b1;
   end

   // Pending bits; a set in the same cycle as a clear wins because it belongs to a younger issue.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST)
         pending_q <= '0;
      else
         pending_q <= (pending_q & ~clr_mask) | set_mask;
   end

   assign rs = bus.rs_rt[2*ADDR_W-1:ADDR_W];
   assign rt = bus.rs_rt[ADDR_W-1:0];

   // Hazard: outstanding write to a source, or a write sitting in the output register this cycle.
   always_comb begin
      hazard_c = 1'b0;
      if (rs != '0 && (pending_q[rs] || rwd_q == rs))
         hazard_c = 1'b1;
      if (rt != '0 && (pending_q[rt] || rwd_q == rt))
         hazard_c = 1'b1;
   end

   assign bus.a_ready    = a_ready_c;
   assign bus.b_ready    = b_ready_c;
   assign bus.hazard     = hazard_c;
   assign bus.rwd        = rwd_q;
   assign bus.wb_data    = wb_data_q;
   assign bus.pending    = pending_q;
   assign bus.last_grant = (last_q == GRANT_B);
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 5;
   localparam int SB_W   = 3 + ADDR_W + DATA_W;

   logic CLK;
   logic RST;

   rf_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   rf_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus.slave)
   );

   // clock / reset
   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_pass   = 0;

   // scoreboard: {a_ready, b_ready, hazard, rwd, wb_data}
   logic [SB_W-1:0] exp_q[$];

   // reference model state
   logic              last_m;   // 1 = B granted last
   logic [ADDR_W-1:0] rwd_m;
   logic [DATA_W-1:0] wb_m;
   logic [31:0]       pend_m;

   task automatic reset_model();
      last_m = 1'b1;
      rwd_m  = '0;
      wb_m   = '0;
      pend_m = '0;
      exp_q.delete();
   endtask

   task automatic clear_inputs();
      bus.a_valid = 1'b0; bus.a_rd = '0; bus.a_data = '0;
      bus.b_valid = 1'b0; bus.b_rd = '0; bus.b_data = '0;
      bus.issue_valid = 1'b0; bus.issue_rd = '0; bus.rs_rt = '0;
   endtask

   task automatic do_reset();
      RST = 1'b1;
      clear_inputs();
      @(posedge CLK); #1;
      RST = 1'b0;
      reset_model();
   endtask

   // Driver: presents one cycle of stimulus, pushes the model's expectation,
   // and returns what the DUT showed (ready/hazard before the edge, outputs after).
   task automatic drive_cycle(
      input  logic              av,  input logic [ADDR_W-1:0] ard, input logic [DATA_W-1:0] adat,
      input  logic              bv,  input logic [ADDR_W-1:0] brd, input logic [DATA_W-1:0] bdat,
      input  logic              iv,  input logic [ADDR_W-1:0] ird, input logic [2*ADDR_W-1:0] rsrt,
      output logic [SB_W-1:0]   obs);
      logic ea, eb, eh, sa, sb, sh;
      logic [ADDR_W-1:0] rs, rt, n_rwd;
      logic [31:0] set_v, clr_v;
      bus.a_valid = av; bus.a_rd = ard; bus.a_data = adat;
      bus.b_valid = bv; bus.b_rd = brd; bus.b_data = bdat;
      bus.issue_valid = iv; bus.issue_rd = ird; bus.rs_rt = rsrt;
      #1;
      rs = rsrt[2*ADDR_W-1:ADDR_W];
      rt = rsrt[ADDR_W-1:0];
      eh = (rs != 0 && pend_m[rs]) || (rt != 0 && pend_m[rt]) ||
           (rwd_m != 0 && (rwd_m == rs || rwd_m == rt));
      ea = av && (!bv || last_m);
      eb = bv && (!av || !last_m);
      set_v = (iv && ird != 0) ? (32'd1 << ird) : 32'd0;
      clr_v = 32'd0;
      if (ea) begin
         n_rwd = ard; wb_m = adat; last_m = 1'b0;
         if (ard != 0) clr_v = 32'd1 << ard;
      end else if (eb) begin
         n_rwd = brd; wb_m = bdat; last_m = 1'b1;
         if (brd != 0) clr_v = 32'd1 << brd;
      end else begin
         n_rwd = '0;
      end
      exp_q.push_back({ea, eb, eh, n_rwd, wb_m});
      pend_m = (pend_m & ~clr_v) | set_v;
      sa = bus.a_ready; sb = bus.b_ready; sh = bus.hazard;
      @(posedge CLK); #1;
      rwd_m = n_rwd;
      obs = {sa, sb, sh, bus.rwd, bus.wb_data};
   endtask

   task automatic test_reset();
      logic [SB_W-1:0] obs, exp;
      RST = 1'b1;
      clear_inputs();
      bus.a_valid = 1'b1; bus.a_rd = 5'd3;
      @(posedge CLK); #1;
      n_checks++; if (bus.a_ready !== 1'b0) $display("FAIL reset_hold_a_ready: got %b expected 0", bus.a_ready); else n_pass++;
      n_checks++; if (bus.rwd !== '0) $display("FAIL reset_hold_rwd: got %0d expected 0", bus.rwd); else n_pass++;
      n_checks++; if (bus.pending !== '0) $display("FAIL reset_hold_pending: got %h expected 0", bus.pending); else n_pass++;
      RST = 1'b0;
      reset_model();
      drive_cycle(1'b1, 5'd4, 32'h0000_0444, 1'b0, '0, '0, 1'b1, 5'd3, '0, obs);
      exp = exp_q.pop_front();
      n_checks++; if (obs !== exp) $display("FAIL reset_pre_sb: got %h expected %h", obs, exp); else n_pass++;
      n_checks++; if (bus.pending[3] !== 1'b1 || bus.rwd !== 5'd4) $display("FAIL reset_pre_state: got pending3=%b rwd=%0d expected 1/4", bus.pending[3], bus.rwd); else n_pass++;
      // assert reset mid-cycle with A presenting a write to r3
      bus.a_valid = 1'b1; bus.a_rd = 5'd3; bus.a_data = 32'h33; bus.issue_valid = 1'b0;
      #2;
      RST = 1'b1;
      #1;
      n_checks++; if (bus.rwd !== '0 || bus.wb_data !== '0) $display("FAIL reset_async_out: got rwd=%0d wb=%h expected 0/0", bus.rwd, bus.wb_data); else n_pass++;
      n_checks++; if (bus.pending !== '0) $display("FAIL reset_async_pending: got %h expected 0", bus.pending); else n_pass++;
      n_checks++; if (bus.a_ready !== 1'b0) $display("FAIL reset_async_a_ready: got %b expected 0", bus.a_ready); else n_pass++;
      clear_inputs();
      @(posedge CLK); #1;
      RST = 1'b0;
      reset_model();
      // first contention after reset must go to A
      drive_cycle(1'b1, 5'd10, 32'h0000_00AA, 1'b1, 5'd11, 32'h0000_00BB, 1'b0, '0, '0, obs);
      exp = exp_q.pop_front();
      n_checks++; if (obs !== exp) $display("FAIL reset_first_grant_sb: got %h expected %h", obs, exp); else n_pass++;
      n_checks++; if (obs[SB_W-1] !== 1'b1 || bus.rwd !== 5'd10) $display("FAIL reset_first_grant: got a_ready=%b rwd=%0d expected 1/10", obs[SB_W-1], bus.rwd); else n_pass++;
   endtask

   task automatic test_single();
      logic [SB_W-1:0] obs, exp;
      drive_cycle(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, '0, '0, 1'b0, '0, '0, obs);
      exp = exp_q.pop_front();
      n_checks++; if (obs !== exp) $display("FAIL single_sb: got %h expected %h", obs, exp); else n_pass++;
      n_checks++; if (obs[SB_W-1] !== 1'b1 || bus.rwd !== 5'd5 || bus.wb_data !== 32'hDEAD_BEEF)
         $display("FAIL single_write: got a_ready=%b rwd=%0d wb=%h expected 1/5/deadbeef", obs[SB_W-1], bus.rwd, bus.wb_data); else n_pass++;
      drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, '0, obs);
      exp = exp_q.pop_front();
      n_checks++; if (obs !== exp) $display("FAIL single_idle_sb: got %h expected %h", obs, exp); else n_pass++;
      n_checks++; if (bus.rwd !== '0 || bus.wb_data !== 32'hDEAD_BEEF)
         $display("FAIL single_idle: got rwd=%0d wb=%h expected 0/deadbeef", bus.rwd, bus.wb_data); else n_pass++;
   endtask

   task automatic test_contention();
      logic [SB_W-1:0] obs, exp;
      logic [ADDR_W-1:0] want;
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive_cycle(1'b1, 5'd1, 32'hA000_0000 + i, 1'b1, 5'd2, 32'hB000_0000 + i, 1'b0, '0, '0, obs);
         exp = exp_q.pop_front();
         want = (i % 2 == 0) ? 5'd1 : 5'd2;
         n_checks++; if (obs !== exp) $display("FAIL contention_sb[%0d]: got %h expected %h", i, obs, exp); else n_pass++;
         n_checks++; if (bus.rwd !== want) $display("FAIL contention_rwd[%0d]: got %0d expected %0d", i, bus.rwd, want); else n_pass++;
      end
   endtask

   task automatic test_reg_zero();
      logic [SB_W-1:0] obs, exp;
      // A alone leaves last = A, so only a B grant to r0 can make A win next
      drive_cycle(1'b1, 5'd6, 32'h0000_0006, 1'b0, '0, '0, 1'b0, '0, '0, obs);
      exp = exp_q.pop_front();
      n_checks++; if (obs !== exp) $display("FAIL reg0_pre_sb: got %h expected %h", obs, exp); else n_pass++;
      drive_cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'h0000_0055, 1'b0, '0, '0, obs);
      exp = exp_q.pop_front();
      n_checks++; if (obs !== exp) $display("FAIL reg0_sb: got %h expected %h", obs, exp); else n_pass++;
      n_checks++; if (obs[SB_W-2] !== 1'b1 || bus.rwd !== '0 || bus.last_grant !== 1'b1)
         $display("FAIL reg0_write: got b_ready=%b rwd=%0d last=%b expected 1/0/1", obs[SB_W-2], bus.rwd, bus.last_grant); else n_pass++;
      drive_cycle(1'b1, 5'd12, 32'h0000_0C0C, 1'b1, 5'd13, 32'h0000_0D0D, 1'b0, '0, '0, obs);
      exp = exp_q.pop_front();
      n_checks++; if (obs !== exp) $display("FAIL reg0_next_sb: got %h expected %h", obs, exp); else n_pass++;
      n_checks++; if (bus.rwd !== 5'd12) $display("FAIL reg0_next_grant: got rwd=%0d expected 12", bus.rwd); else n_pass++;
   endtask

   task automatic test_scoreboard();
      logic [SB_W-1:0] obs, exp;
      logic [2*ADDR_W-1:0] src;
      src = {5'd7, 5'd0};
      drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd7, '0, obs);
      exp = exp_q.pop_front();
      n_checks++; if (obs !== exp) $display("FAIL sb_issue_sb: got %h expected %h", obs, exp); else n_pass++;
      for (int i = 0; i < 4; i++) begin
         if (i == 1) drive_cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'h0000_0077, 1'b0, '0, src, obs);
         else        drive_cycle(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, src, obs);
         exp = exp_q.pop_front();
         n_checks++; if (obs !== exp) $display("FAIL sb_hazard_sb[%0d]: got %h expected %h", i, obs, exp); else n_pass++;
         n_checks++; if (obs[SB_W-3] !== (i < 3)) $display("FAIL sb_hazard[%0d]: got %b expected %b", i, obs[SB_W-3], (i < 3)); else n_pass++;
         if (i == 1) begin
            n_checks++; if (bus.pending[7] !== 1'b0 || bus.rwd !== 5'd7)
               $display("FAIL sb_clear: got pending7=%b rwd=%0d expected 0/7", bus.pending[7], bus.rwd); else n_pass++;
         end
      end
   endtask

   task automatic test_collision();
      logic [SB_W-1:0] obs, exp;
      drive_cycle(1'b1, 5'd9, 32'h0000_0099, 1'b0, '0, '0, 1'b1, 5'd9, '0, obs);
      exp = exp_q.pop_front();
      n_checks++; if (obs !== exp) $display("FAIL collision_sb: got %h expected %h", obs, exp); else n_pass++;
      n_checks++; if (bus.pending[9] !== 1'b1 || bus.rwd !== 5'd9)
         $display("FAIL collision_set_wins: got pending9=%b rwd=%0d expected 1/9", bus.pending[9], bus.rwd); else n_pass++;
      drive_cycle(1'b0, '0, '0, 1'b1, 5'd9, 32'h0000_0999, 1'b0, '0, '0, obs);
      exp = exp_q.pop_front();
      n_checks++; if (obs !== exp) $display("FAIL collision_clear_sb: got %h expected %h", obs, exp); else n_pass++;
      n_checks++; if (bus.pending[9] !== 1'b0) $display("FAIL collision_clear: got pending9=%b expected 0", bus.pending[9]); else n_pass++;
   endtask

   task automatic test_random();
      logic [SB_W-1:0] obs, exp;
      logic av, bv, iv;
      logic [ADDR_W-1:0] ard, brd, ird;
      logic [DATA_W-1:0] adat, bdat;
      av = 1'b0; bv = 1'b0; ard = '0; brd = '0; adat = '0; bdat = '0;
      for (int i = 0; i < 80; i++) begin
         // requesters hold their write until it is accepted
         if (!av && $urandom_range(0, 3) != 0) begin
            av = 1'b1; ard = 5'($urandom_range(0, 7)); adat = $urandom;
         end
         if (!bv && $urandom_range(0, 3) != 0) begin
            bv = 1'b1; brd = 5'($urandom_range(0, 7)); bdat = $urandom;
         end
         iv  = ($urandom_range(0, 1) == 1);
         ird = 5'($urandom_range(0, 7));
         drive_cycle(av, ard, adat, bv, brd, bdat, iv, ird,
                     {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))}, obs);
         exp = exp_q.pop_front();
         n_checks++; if (obs !== exp) $display("FAIL random_sb[%0d]: got %h expected %h", i, obs, exp); else n_pass++;
         n_checks++; if (bus.pending !== pend_m) $display("FAIL random_pending[%0d]: got %h expected %h", i, bus.pending, pend_m); else n_pass++;
         if (exp[SB_W-1]) av = 1'b0;
         if (exp[SB_W-2]) bv = 1'b0;
      end
   endtask

   initial begin
      RST = 1'b1;
      clear_inputs();
      reset_model();
      repeat (2) @(posedge CLK);
      #1;
      test_reset();
      test_single();
      test_contention();
      test_reg_zero();
      test_scoreboard();
      test_collision();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
